// File: rtl/time_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by a 1 Hz enable, with a
// mode/increment state machine for setting hours and minutes from button pulses.
module time_counter #(
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  localparam int unsigned FIELD_W = 8;
  localparam logic [FIELD_W-1:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
  localparam logic [FIELD_W-1:0] MIN_MAX_BCD  = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [FIELD_W-1:0] sec_nxt, min_nxt, hour_nxt;
  logic               blink_nxt, day_pulse_nxt;

  logic [FIELD_W-1:0] sec_inc, min_inc, hour_inc;
  logic               sec_cy, min_cy, hour_cy;

  // Two-digit BCD increment; returns {carry, value}, wrapping to 00 at max.
  function automatic logic [FIELD_W:0] bcd_inc(input logic [FIELD_W-1:0] v,
                                               input logic [FIELD_W-1:0] max);
    logic [FIELD_W:0] r;
    if (v == max)            r = {1'b1, 8'h00};
    else if (v[3:0] == 4'd9) r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign {sec_cy, sec_inc}   = bcd_inc(sec_bcd, MIN_MAX_BCD);
  assign {min_cy, min_inc}   = bcd_inc(min_bcd, MIN_MAX_BCD);
  assign {hour_cy, hour_inc} = bcd_inc(hour_bcd, HOUR_MAX_BCD);

  assign mode = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      sec_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hour_bcd  <= 8'h00;
      blink     <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      sec_bcd   <= sec_nxt;
      min_bcd   <= min_nxt;
      hour_bcd  <= hour_nxt;
      blink     <= blink_nxt;
      day_pulse <= day_pulse_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sec_nxt       = sec_bcd;
    min_nxt       = min_bcd;
    hour_nxt      = hour_bcd;
    blink_nxt     = 1'b0;
    day_pulse_nxt = 1'b0;
    unique case (state)
      RUN: begin
        if (btn_mode) begin
          // Entering set mode drops any coincident tick and zeroes seconds.
          state_nxt = SET_HOUR;
          sec_nxt   = 8'h00;
        end else if (en_1hz) begin
          sec_nxt = sec_inc;
          if (sec_cy) begin
            min_nxt = min_inc;
            if (min_cy) begin
              hour_nxt      = hour_inc;
              day_pulse_nxt = hour_cy;
            end
          end
        end
      end
      SET_HOUR: begin
        sec_nxt = 8'h00;
        if (btn_mode) begin
          state_nxt = SET_MIN;
        end else begin
          blink_nxt = blink ^ en_1hz;
          if (btn_inc) hour_nxt = hour_inc;
        end
      end
      SET_MIN: begin
        sec_nxt = 8'h00;
        if (btn_mode) begin
          state_nxt = RUN;
        end else begin
          blink_nxt = blink ^ en_1hz;
          if (btn_inc) min_nxt = min_inc;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter: counting, rollover, set modes,
// simultaneous-event priority and reset out of set mode.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       rst, en_1hz, btn_mode, btn_inc;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic [1:0] mode;
  logic       blink, day_pulse;

  int checks = 0;
  int errors = 0;
  logic day_seen;

  time_counter dut (
    .clk(clk), .rst(rst), .en_1hz(en_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
    .mode(mode), .blink(blink), .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, "_time"}, {8'h00, hour_bcd, min_bcd, sec_bcd}, {8'h00, h, m, s});
  endtask

  // One clock with the given inputs, then sample #1 after the edge.
  task automatic step(input logic r, input logic m, input logic i, input logic t);
    rst = r; btn_mode = m; btn_inc = i; en_1hz = t;
    @(posedge clk);
    #1;
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; en_1hz = 1'b0;
    day_seen = day_seen | day_pulse;
  endtask

  task automatic tick_spaced();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; day_seen = 1'b0;

    // Reset, including inputs asserted alongside it.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_blink", 32'(blink), 32'd0);
    check("reset_day", 32'(day_pulse), 32'd0);

    // 61 ticks, five cycles apart.
    day_seen = 1'b0;
    repeat (10) tick_spaced();
    check_time("ten_ticks", 8'h00, 8'h00, 8'h10);
    repeat (51) tick_spaced();
    check_time("61_ticks", 8'h00, 8'h01, 8'h01);
    check("61_mode", 32'(mode), 32'd0);
    check("61_no_day", 32'(day_seen), 32'd0);

    // Preload 23:59 via set mode, then count up to the day rollover.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("enter_set_hour", 32'(mode), 32'd1);
    check_time("enter_set_hour", 8'h00, 8'h01, 8'h00);
    repeat (23) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("hour_23", 32'(hour_bcd), 32'h23);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (58) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("min_59", 32'(min_bcd), 32'h59);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("back_run", 32'(mode), 32'd0);
    check_time("preload", 8'h23, 8'h59, 8'h00);
    day_seen = 1'b0;
    repeat (58) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("pre58", 8'h23, 8'h59, 8'h58);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("pre59", 8'h23, 8'h59, 8'h59);
    check("pre59_day", 32'(day_seen), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("rollover", 8'h00, 8'h00, 8'h00);
    check("rollover_day", 32'(day_pulse), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("day_one_cycle", 32'(day_pulse), 32'd0);

    // SET_HOUR: 25 increments wrap 23->00 and land on 01.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    day_seen = 1'b0;
    repeat (25) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("set_hour_mode", 32'(mode), 32'd1);
    check_time("hour_wrap", 8'h01, 8'h00, 8'h00);
    check("hour_wrap_no_day", 32'(day_seen), 32'd0);

    // SET_MIN: 60 increments return minutes to their value, no hour carry.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("min_07", 32'(min_bcd), 32'h07);
    repeat (60) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("set_min_mode", 32'(mode), 32'd2);
    check_time("min_wrap", 8'h01, 8'h07, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("min_to_run", 32'(mode), 32'd0);

    // Blink toggling in SET_HOUR; seconds frozen.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_start", 32'(blink), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("blink_1", 32'(blink), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("blink_2", 32'(blink), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("blink_3", 32'(blink), 32'd1);
    check("blink_sec", 32'(sec_bcd), 32'h00);
    // Tick and increment together: both take effect.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("inc_tick_blink", 32'(blink), 32'd0);
    check("inc_tick_hour", 32'(hour_bcd), 32'h02);
    // Mode beats increment.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("mode_prio_mode", 32'(mode), 32'd2);
    check("mode_prio_hour", 32'(hour_bcd), 32'h02);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("set_min_blink", 32'(blink), 32'd1);
    check("set_min_no_count", 32'(min_bcd), 32'h07);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("run_blink0", 32'(blink), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_time("run_inc_ignored", 8'h02, 8'h07, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("run_resume", 8'h02, 8'h07, 8'h01);
    check("run_blink_held", 32'(blink), 32'd0);

    // Tick coincident with btn_mode is dropped.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("at_09", 8'h00, 8'h00, 8'h09);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("drop_tick_mode", 32'(mode), 32'd1);
    check_time("drop_tick", 8'h00, 8'h00, 8'h00);

    // Reset out of SET_MIN.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("pre_rst_min", 32'(min_bcd), 32'h03);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_time("rst_set_min", 8'h00, 8'h00, 8'h00);
    check("rst_set_min_mode", 32'(mode), 32'd0);
    check("rst_set_min_blink", 32'(blink), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
